seg7_capture: RTL
=================

# seg7_capture

Frame-level capture for a time-multiplexed, active-low seven-segment display bus; it converts segment patterns back into hex nibbles. The block samples the shared segment lines and per-digit enables, requires each digit's pattern to be stable before capturing it, and decodes each pattern to a hex nibble. When every digit has been captured, it publishes the assembled multi-digit value. It sits on the observation side of the display path, for self-check and loopback of what the board actually drives.

## Interface
Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (1..8)
- STABLE_CYCLES, 4, consecutive identical cycles required before a capture (>=1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- seg_n  in  7  shared segment lines, active-low, bit0=a … bit6=g
- digit_en_n  in  NUM_DIGITS  digit enables, active-low, one-hot when valid
- value  out  4*NUM_DIGITS  captured frame; nibble i = digit i
- invalid_mask  out  NUM_DIGITS  bit i set = digit i pattern not a hex glyph in this frame
- frame_valid  out  1  one-cycle pulse when value/invalid_mask update
- enable_error  out  1  one-cycle pulse when digit_en_n has more than one bit low

## Operation
- Glyph table, active-low, g..a: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Any other pattern decodes to nibble 0 and sets invalid for that digit.
- Inputs pass through a 2-flop synchronizer first. All logic below sees the synchronized copies.
- FSM states:
  - IDLE: no single enable is low. Stability counter is cleared.
  - SETTLE: exactly one enable is low. The counter increments while {seg_n, digit_en_n} equals the previous cycle's value. Any change restarts the counter at 1.
  - HOLD: the digit has been captured. No further capture occurs until digit_en_n changes.
- Transitions:
  - IDLE→SETTLE when the enables become one-hot.
  - SETTLE→HOLD when the counter reaches STABLE_CYCLES. The capture is written into the staging slot for that digit, and the digit's captured_mask bit is set.
  - HOLD or SETTLE→SETTLE when the one-hot enable changes to another digit.
  - Any state→IDLE when the enables go to all-high or multi-low.
- Multi-low enables:
  - enable_error pulses for each such cycle.
  - No capture is made.
  - captured_mask is not cleared.
- Frame completion:
  - Triggered by a capture that makes captured_mask all ones.
  - Next cycle: staging is copied to value/invalid_mask, frame_valid pulses, and captured_mask clears.
  - If the same digit is recaptured before the frame completes, it overwrites its staging slot. The frame is not published.
- Scan order is irrelevant; only coverage of all digits matters.

## Timing
- Reset values: value=0, invalid_mask=0, frame_valid=0, enable_error=0. FSM=IDLE, counter=0, captured_mask=0, synchronizer flops=all ones.
- Input to internal view: 2 cycles.
- Capture occurs on the STABLE_CYCLES-th consecutive identical synchronized cycle.
- frame_valid asserts 1 cycle after the completing capture.
- Total latency from the final digit's stable input to frame_valid: 2+STABLE_CYCLES+1 cycles.
- enable_error asserts 1 cycle after the synchronized multi-low view.
- Counter saturates at STABLE_CYCLES. A digit window held indefinitely captures exactly once.
- Reset mid-frame discards the staging contents and captured_mask. value keeps no history.
- STABLE_CYCLES=1: capture occurs on the first one-hot cycle. Every enable change is a new window.

## Configuration
- SEG7_CAPTURE_DP_EN defined:
  - Adds input dp_n (1 bit, active-low decimal point) and output dp_mask (NUM_DIGITS).
  - dp_n is synchronized and is part of the stability comparison.
  - dp_mask is captured per digit and published with value.
- SEG7_CAPTURE_DP_EN undefined:
  - Neither port exists.
  - Decimal point is not observed and does not affect stability.

## Structure
- seg7_pkg: the 16 glyph constants (shared with the display-side hex encoder), the segment bit-order constants, and the FSM state enum.
- Sub-module seg7_glyph_decode: combinational, 7-bit pattern → {nibble, valid}, table from seg7_pkg.
- FSM, counter, staging registers and frame logic stay in seg7_capture.

## Test plan
- NUM_DIGITS=4, STABLE_CYCLES=4:
  - Drive digit 0..3 with patterns 1,2,A,F, 6 cycles each → one frame_valid with value=16'hFA21 and invalid_mask=0.
  - Digit 2 pattern 1111111 (blank), others valid → value nibble 2 = 0, invalid_mask=4'b0100.
  - Digit 1 pattern toggling every 3 cycles → no capture and no frame_valid. Holding it stable for 4 cycles then produces the frame.
  - digit_en_n=4'b1100 for 2 cycles mid-scan → two enable_error pulses, no capture. The frame completes once the remaining digits are scanned.
  - Assert rst_n low after 3 digits are captured, release, then scan all 4 digits → exactly one frame_valid, with only post-reset data. All outputs read 0 during reset.
  - SEG7_CAPTURE_DP_EN, dp_n low on digit 3 only → dp_mask=4'b1000 alongside value.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment bit order, active-low hex glyphs
// and the capture FSM state encoding.
package seg7_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam int SEG_W = SEG_G + 1;

  // Active-low patterns, written g..a (MSB = segment g).
  localparam logic [SEG_W-1:0] GLYPH_0 = 7'b1000000;
  localparam logic [SEG_W-1:0] GLYPH_1 = 7'b1111001;
  localparam logic [SEG_W-1:0] GLYPH_2 = 7'b0100100;
  localparam logic [SEG_W-1:0] GLYPH_3 = 7'b0110000;
  localparam logic [SEG_W-1:0] GLYPH_4 = 7'b0011001;
  localparam logic [SEG_W-1:0] GLYPH_5 = 7'b0010010;
  localparam logic [SEG_W-1:0] GLYPH_6 = 7'b0000010;
  localparam logic [SEG_W-1:0] GLYPH_7 = 7'b1111000;
  localparam logic [SEG_W-1:0] GLYPH_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] GLYPH_9 = 7'b0010000;
  localparam logic [SEG_W-1:0] GLYPH_A = 7'b0001000;
  localparam logic [SEG_W-1:0] GLYPH_B = 7'b0000011;
  localparam logic [SEG_W-1:0] GLYPH_C = 7'b1000110;
  localparam logic [SEG_W-1:0] GLYPH_D = 7'b0100001;
  localparam logic [SEG_W-1:0] GLYPH_E = 7'b0000110;
  localparam logic [SEG_W-1:0] GLYPH_F = 7'b0001110;

  localparam logic [SEG_W-1:0] GLYPH_TABLE [16] = '{
    GLYPH_0, GLYPH_1, GLYPH_2, GLYPH_3, GLYPH_4, GLYPH_5, GLYPH_6, GLYPH_7,
    GLYPH_8, GLYPH_9, GLYPH_A, GLYPH_B, GLYPH_C, GLYPH_D, GLYPH_E, GLYPH_F
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } cap_state_e;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational inverse of the hex glyph table: active-low segment pattern to
// nibble; unknown patterns give nibble 0 with valid low.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] pattern,
  output logic [3:0]       nibble,
  output logic             valid
);

  // NOTE: every output gets a default before the search loop, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    nibble = '0;
    valid  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == GLYPH_TABLE[i]) begin
        nibble = 4'(i);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_capture.sv
// Frame capture of a multiplexed active-low seven-segment bus back into hex.
// Optional decimal-point observation: define SEG7_CAPTURE_DP_EN.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SEG_W-1:0]        seg_n,
`ifdef SEG7_CAPTURE_DP_EN
  input  logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   dp_mask,
`endif
  input  logic [NUM_DIGITS-1:0]   digit_en_n,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   invalid_mask,
  output logic                    frame_valid,
  output logic                    enable_error
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0]         ONE_C = CW'(1);
  localparam logic [CW-1:0]         STABLE_C = CW'(STABLE_CYCLES);
  localparam logic [NUM_DIGITS-1:0] ONE_D = NUM_DIGITS'(1);

`ifdef SEG7_CAPTURE_DP_EN
  localparam int OBS_W = SEG_W + 1;
  logic [OBS_W-1:0] obs_raw;
  assign obs_raw = {dp_n, seg_n};
`else
  localparam int OBS_W = SEG_W;
  logic [OBS_W-1:0] obs_raw;
  assign obs_raw = seg_n;
`endif

  logic [OBS_W-1:0]      obs_meta, obs_sync, obs_prev;
  logic [NUM_DIGITS-1:0] en_meta, en_sync, en_prev;

  // Idle bus level is all ones (nothing lit, no digit enabled).
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, as the hardware does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      obs_meta <= '1;
      obs_sync <= '1;
      obs_prev <= '1;
      en_meta  <= '1;
      en_sync  <= '1;
      en_prev  <= '1;
    end else begin
      obs_meta <= obs_raw;
      obs_sync <= obs_meta;
      obs_prev <= obs_sync;
      en_meta  <= digit_en_n;
      en_sync  <= en_meta;
      en_prev  <= en_sync;
    end
  end

  logic [NUM_DIGITS-1:0] en_low;
  logic                  one_hot, multi_low, same;
  logic [DW-1:0]         digit_idx;

  assign en_low    = ~en_sync;
  assign one_hot   = (en_low != '0) && ((en_low & (en_low - ONE_D)) == '0);
  assign multi_low = (en_low != '0) && !one_hot;
  assign same      = (obs_sync == obs_prev) && (en_sync == en_prev);

  always_comb begin
    digit_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (en_low[i]) digit_idx = DW'(i);
    end
  end

  logic [3:0] dec_nibble;
  logic       dec_valid;

  seg7_glyph_decode u_decode (
    .pattern (obs_sync[SEG_W-1:0]),
    .nibble  (dec_nibble),
    .valid   (dec_valid)
  );

  cap_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, run;
  logic          capture;

  // run is the length of the current identical-sample streak including this
  // cycle; a window held in HOLD never re-arms until the enable moves.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    run     = '0;
    capture = 1'b0;
    if (!one_hot) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (state_q == ST_HOLD && en_sync == en_prev) begin
      state_d = ST_HOLD;
    end else begin
      run   = (state_q == ST_SETTLE && same) ? cnt_q + ONE_C : ONE_C;
      cnt_d = run;
      if (run == STABLE_C) begin
        capture = 1'b1;
        state_d = ST_HOLD;
      end else begin
        state_d = ST_SETTLE;
      end
    end
  end

  logic [4*NUM_DIGITS-1:0] stage_value;
  logic [NUM_DIGITS-1:0]   stage_inv, captured_mask, mask_d;
  logic                    mask_full;

  // A full mask only ever arises from a capture, so publishing the cycle after
  // it appears is exactly "one cycle after the completing capture".
  assign mask_full = &captured_mask;
  assign mask_d    = (mask_full ? '0 : captured_mask) | (capture ? en_low : '0);

`ifdef SEG7_CAPTURE_DP_EN
  logic [NUM_DIGITS-1:0] stage_dp;
`endif

  // NOTE: staging is reset along with the mask, so a reset mid-frame can never
  // leak pre-reset digits into a later frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      captured_mask <= '0;
      stage_value   <= '0;
      stage_inv     <= '0;
      value         <= '0;
      invalid_mask  <= '0;
      frame_valid   <= 1'b0;
      enable_error  <= 1'b0;
`ifdef SEG7_CAPTURE_DP_EN
      stage_dp      <= '0;
      dp_mask       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      captured_mask <= mask_d;
      frame_valid   <= mask_full;
      enable_error  <= multi_low;
      if (capture) begin
        stage_value[4*digit_idx +: 4] <= dec_nibble;
        stage_inv[digit_idx]          <= ~dec_valid;
`ifdef SEG7_CAPTURE_DP_EN
        stage_dp[digit_idx]           <= ~obs_sync[SEG_W];
`endif
      end
      if (mask_full) begin
        value        <= stage_value;
        invalid_mask <= stage_inv;
`ifdef SEG7_CAPTURE_DP_EN
        dp_mask      <= stage_dp;
`endif
      end
    end
  end

endmodule
